// File: rtl/xor_stream_cipher.sv
// xor_stream_cipher: serial key/message loader, one-cycle repeating-key XOR, serial ciphertext out with valid/ready
// Ports:
//   clk, rst_n (sync, active-low), ena (freezes everything when low)
//   data_in, key_load, msg_load : shared serial load pin, MSB first; key wins on contention
//   out_ready / out_valid / out_data : ciphertext stream handshake, MSB first
//   key_full : key register holds KEY_SIZE bits; busy : ENCRYPT or SHIFT; done : one-cycle end pulse
// Optional feature: define XOR_KEY_ROTATE_EN to rotate the key left by one bit per key-sized block.
module xor_stream_cipher #(
    parameter int KEY_SIZE = 8,
    parameter int MSG_SIZE = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic data_in,
    input  logic key_load,
    input  logic msg_load,
    input  logic out_ready,
    output logic out_valid,
    output logic out_data,
    output logic key_full,
    output logic busy,
    output logic done
);
    localparam int KW = $clog2(KEY_SIZE) + 1;
    localparam int MW = $clog2(MSG_SIZE) + 1;
    localparam int NB = MSG_SIZE / KEY_SIZE;
    localparam logic [KW-1:0] KEY_FULL = KW'(KEY_SIZE);
    localparam logic [MW-1:0] MSG_FULL = MW'(MSG_SIZE);
    localparam logic [MW-1:0] OUT_LAST = MW'(MSG_SIZE - 1);

    typedef enum logic [1:0] {IDLE, ENCRYPT, SHIFT} state_t;

    state_t              r_state, w_next;
    logic [KEY_SIZE-1:0] r_key;
    logic [MSG_SIZE-1:0] r_msg, r_ct, w_ct;
    logic [KW-1:0]       r_key_cnt;
    logic [MW-1:0]       r_msg_cnt, r_out_cnt;
    logic                r_done;
    logic                w_start, w_accept, w_last;
`ifdef XOR_KEY_ROTATE_EN
    logic [2*KEY_SIZE-1:0] w_kk;
`endif

    assign w_start  = (r_msg_cnt == MSG_FULL) && key_full;
    assign w_accept = out_valid && out_ready;
    assign w_last   = w_accept && (r_out_cnt == OUT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else if (ena)
            r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE && w_start) ? ENCRYPT :
                 (r_state == ENCRYPT)         ? SHIFT   :
                 (r_state == SHIFT && w_last) ? IDLE    : r_state;
    end

    always_comb begin
        out_valid = (r_state == SHIFT);
        out_data  = out_valid & r_ct[MSG_SIZE-1];
        busy      = (r_state != IDLE);
        key_full  = (r_key_cnt == KEY_FULL);
        done      = r_done;
    end

    // Block b counts from the MSB end; rotl(key, r) is the upper half of {key,key} shifted left by r.
    always_comb begin
        w_ct = '0;
`ifdef XOR_KEY_ROTATE_EN
        w_kk = {r_key, r_key};
        for (int b = 0; b < NB; b++)
            w_ct[MSG_SIZE-1-b*KEY_SIZE -: KEY_SIZE] = r_msg[MSG_SIZE-1-b*KEY_SIZE -: KEY_SIZE]
                                                    ^ w_kk[2*KEY_SIZE-1-(b%KEY_SIZE) -: KEY_SIZE];
`else
        for (int b = 0; b < NB; b++)
            w_ct[MSG_SIZE-1-b*KEY_SIZE -: KEY_SIZE] = r_msg[MSG_SIZE-1-b*KEY_SIZE -: KEY_SIZE] ^ r_key;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key     <= '0;
            r_msg     <= '0;
            r_ct      <= '0;
            r_key_cnt <= '0;
            r_msg_cnt <= '0;
            r_out_cnt <= '0;
            r_done    <= 1'b0;
        end else if (ena) begin
            r_done <= w_last;
            if (r_state == IDLE) begin
                if (key_load) begin
                    if (!key_full) begin
                        r_key     <= {r_key[KEY_SIZE-2:0], data_in};
                        r_key_cnt <= r_key_cnt + 1'b1;
                    end
                end else if (msg_load && r_msg_cnt != MSG_FULL) begin
                    r_msg     <= {r_msg[MSG_SIZE-2:0], data_in};
                    r_msg_cnt <= r_msg_cnt + 1'b1;
                end
            end
            if (r_state == ENCRYPT) begin
                r_ct      <= w_ct;
                r_msg_cnt <= '0;
            end
            if (w_accept) begin
                r_ct      <= r_ct << 1;
                r_out_cnt <= w_last ? '0 : r_out_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_xor_stream_cipher.sv
// tb_xor_stream_cipher: directed and randomized checks of xor_stream_cipher against a bit-level reference model
module tb_xor_stream_cipher;
    logic clk = 0, rst_n = 0, ena = 1, data_in = 0, key_load = 0, msg_load = 0, out_ready = 0;
    logic out_valid, out_data, key_full, busy, done;
    int tests = 0, fails = 0;
    localparam logic [63:0] MSG2 = 64'h0123456789ABCDEF;

    xor_stream_cipher #(.KEY_SIZE(8), .MSG_SIZE(64)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .key_load(key_load),
        .msg_load(msg_load), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .key_full(key_full), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Ciphertext bit i = msg bit i XOR the key bit at position i%8 of the (possibly rotated) block key.
    function automatic logic [63:0] model(input logic [7:0] k, input logic [63:0] m);
        logic [63:0] r;
        int s;
        r = m;
        for (int i = 0; i < 64; i++) begin
            s = 0;
`ifdef XOR_KEY_ROTATE_EN
            s = ((63 - i) / 8) % 8;
`endif
            r[i] = m[i] ^ k[(i % 8 - s + 8) % 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit is_key, input logic [63:0] v, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                key_load = 0; msg_load = 0; data_in = 1'($urandom);
                tick();
            end
            data_in = v[i]; key_load = is_key; msg_load = !is_key;
            tick();
        end
        key_load = 0; msg_load = 0;
    endtask

    task automatic stream(input string tag, input logic [63:0] exp, input int stall_at, input bit noise);
        logic [63:0] got;
        int n, cyc, st;
        got = '0; n = 0; cyc = 0; st = 0;
        while (n < 64 && cyc < 400) begin
            if (noise) begin
                key_load = 1'($urandom); msg_load = 1'($urandom); data_in = 1'($urandom);
            end
            if (n == stall_at && st < 3) begin
                out_ready = 0; st++;
                chk({tag, " hold"}, {62'b0, out_valid, out_data}, {62'b0, 1'b1, exp[63-n]});
            end else begin
                out_ready = 1;
                if (out_valid) begin
                    got[63-n] = out_data;
                    n++;
                end
            end
            tick();
            cyc++;
        end
        key_load = 0; msg_load = 0;
        chk({tag, " stream"}, got, exp);
        chk({tag, " done"}, {62'b0, done, out_valid}, 64'b10);
        tick();
        chk({tag, " done pulse"}, {62'b0, done, busy}, 64'b0);
    endtask

    initial begin
        logic [7:0] k;
        logic [63:0] m;
        tick(); tick();
        chk("reset outs", {59'b0, out_valid, out_data, key_full, busy, done}, 64'b0);
        rst_n = 1;
        // T2 basic with latency
        send(1, 64'hAC, 8, 0);
        chk("T2 key_full", {63'b0, key_full}, 64'b1);
        send(0, MSG2, 64, 0);
        chk("T2 lat0", {62'b0, busy, out_valid}, 64'b00);
        tick();
        chk("T2 lat1", {62'b0, busy, out_valid}, 64'b10);
        tick();
        chk("T2 lat2", {62'b0, busy, out_valid}, 64'b11);
        stream("T2", 64'hAD8FE9CB25076143, -1, 0);
        // T3 backpressure, key reused
        send(0, MSG2, 64, 0);
        stream("T3", 64'hAD8FE9CB25076143, 11, 0);
        // T6 rotation option
        send(0, 64'h0, 64, 0);
`ifdef XOR_KEY_ROTATE_EN
        stream("T6", 64'hAC59B265CA952B56, -1, 0);
`else
        stream("T6", 64'hACACACACACACACAC, -1, 0);
`endif
        // ena freeze while presenting the first bit
        send(0, MSG2, 64, 0);
        tick(); tick();
        ena = 0; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ena hold", {62'b0, out_valid, out_data}, {62'b0, 1'b1, model(8'hAC, MSG2)[63]});
        end
        ena = 1;
        stream("ena", model(8'hAC, MSG2), -1, 0);
        // T1 reset mid-SHIFT
        send(0, MSG2, 64, 0);
        tick(); tick();
        out_ready = 1;
        repeat (5) tick();
        rst_n = 0;
        tick(); tick();
        chk("T1 outs", {59'b0, out_valid, out_data, key_full, busy, done}, 64'b0);
        rst_n = 1;
        tick();
        chk("T1 idle", {59'b0, out_valid, out_data, key_full, busy, done}, 64'b0);
        // T4 message before key
        send(0, MSG2, 64, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("T4 wait", {62'b0, busy, out_valid}, 64'b0);
        end
        send(1, 64'hAC, 8, 0);
        stream("T4", 64'hAD8FE9CB25076143, -1, 0);
        // T5 contention, then flags toggling during SHIFT
        rst_n = 0; tick(); rst_n = 1;
        data_in = 1; key_load = 1; msg_load = 1;
        repeat (8) tick();
        key_load = 0; msg_load = 0;
        chk("T5 key_full", {62'b0, key_full, busy}, 64'b10);
        send(0, MSG2, 64, 0);
        stream("T5a", model(8'hFF, MSG2), -1, 1);
        send(0, 64'h0F1E2D3C4B5A6978, 64, 0);
        stream("T5b", model(8'hFF, 64'h0F1E2D3C4B5A6978), -1, 1);
        // randomized: one key, several messages, load gaps, backpressure, flag noise
        rst_n = 0; tick(); rst_n = 1;
        k = 8'($urandom);
        send(1, {56'b0, k}, 8, 1);
        for (int r = 0; r < 6; r++) begin
            m = {$urandom, $urandom};
            send(0, m, 64, 1);
            stream("rand", model(k, m), $urandom_range(1, 62), 1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
